// File: rtl/handshake_constant_seq.sv
// Elastic constant source: each accepted ctrl token pushes the next table entry
// into a 2-entry output FIFO so that ctrl_ready depends only on registers.
module handshake_constant_seq #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned NUM_CONSTS = 4,
   parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_TABLE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int unsigned IDX_W = (NUM_CONSTS > 1) ? $clog2(NUM_CONSTS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CONSTS - 1);

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic                  ctrl_ready_q, ctrl_ready_d;
   logic                  outs_valid_q, outs_valid_d;
   logic                  ctrl_fire;
   logic                  out_fire;
   logic [DATA_WIDTH-1:0] cur_const;

   function automatic logic [DATA_WIDTH-1:0] table_entry(input logic [IDX_W-1:0] i);
      table_entry = CONST_TABLE[32'(i) * DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // Next-state: index advance and FIFO push/pop; buf0 is always the head.
   always_comb begin
      idx_d        = idx_q;
      occ_d        = occ_q;
      buf0_d       = buf0_q;
      buf1_d       = buf1_q;
      ctrl_fire    = ctrl_valid & ctrl_ready_q;
      out_fire     = outs_valid_q & outs_ready;
      cur_const    = table_entry(idx_q);

      if (ctrl_fire) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
         idx_d = idx_q;
      end

      case (occ_q)
         2'd0: begin
            if (ctrl_fire) begin
               buf0_d = cur_const;
               occ_d  = 2'd1;
            end else begin
               occ_d  = 2'd0;
            end
         end
         2'd1: begin
            if (ctrl_fire && out_fire) begin
               buf0_d = cur_const;
               occ_d  = 2'd1;
            end else if (ctrl_fire) begin
               buf1_d = cur_const;
               occ_d  = 2'd2;
            end else if (out_fire) begin
               occ_d  = 2'd0;
            end else begin
               occ_d  = 2'd1;
            end
         end
         2'd2: begin
            // ctrl_ready is low when full, so only a pop can happen here
            if (out_fire) begin
               buf0_d = buf1_q;
               occ_d  = 2'd1;
            end else begin
               occ_d  = 2'd2;
            end
         end
         default: begin
            occ_d = 2'd0;
         end
      endcase

      ctrl_ready_d = (occ_d != 2'd2);
      outs_valid_d = (occ_d != 2'd0);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q        <= '0;
         occ_q        <= 2'd0;
         buf0_q       <= '0;
         buf1_q       <= '0;
         ctrl_ready_q <= 1'b1;
         outs_valid_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         occ_q        <= occ_d;
         buf0_q       <= buf0_d;
         buf1_q       <= buf1_d;
         ctrl_ready_q <= ctrl_ready_d;
         outs_valid_q <= outs_valid_d;
      end
   end

   assign ctrl_ready = ctrl_ready_q;
   assign outs_valid = outs_valid_q;
   assign outs       = buf0_q;

endmodule
